// File: rtl/sram_port0_ctrl.sv
// sram_port0_ctrl
// Host-side controller for the read/write port (port 0) of the 32x256 byte-maskable SRAM
// macro. It takes one request at a time, drives the macro pins for exactly one cycle, captures
// read data, and returns a response. It also counts completed reads and writes.
//
// Ports:
//   clk, rst_n            single clock, synchronous active-low reset
//   req_valid/req_ready   request handshake; req_we, req_addr, req_wdata, req_wmask payload
//   rsp_valid/rsp_ready   response handshake; rsp_we echo, rsp_rdata (0 on writes)
//   sram_csb0, sram_web0  macro chip select / write enable, both active low
//   sram_wmask0, sram_addr0, sram_din0, sram_dout0   macro mask, address and data
//   rd_count, wr_count    completed-transaction counters, wrap modulo 2^CNT_WIDTH
module sram_port0_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned NUM_WMASKS = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_we,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic [CNT_WIDTH-1:0]  wr_count
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StCapture,
        StResp
    } state_e;

    state_e                r_state;
    logic                  r_req_ready;
    logic                  r_rsp_valid;
    logic                  r_rsp_we;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_csb;
    logic                  r_web;
    logic [NUM_WMASKS-1:0] r_wmask;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_din;
    logic [CNT_WIDTH-1:0]  r_rd_count;
    logic [CNT_WIDTH-1:0]  r_wr_count;
    logic                  r_is_write;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_we    <= 1'b0;
            r_rsp_rdata <= '0;
            r_csb       <= 1'b1;
            r_web       <= 1'b1;
            r_wmask     <= '0;
            r_addr      <= '0;
            r_din       <= '0;
            r_rd_count  <= '0;
            r_wr_count  <= '0;
            r_is_write  <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_req_ready <= 1'b1;
                    // r_req_ready is low in the first cycle after reset, so no accept there
                    if (req_valid && r_req_ready) begin
                        r_addr      <= req_addr;
                        r_din       <= req_wdata;
                        r_wmask     <= req_wmask;
                        r_csb       <= 1'b0;
                        r_web       <= ~req_we;
                        r_is_write  <= req_we;
                        r_req_ready <= 1'b0;
                        r_state     <= StIssue;
                    end
                end
                StIssue: begin
                    // Macro samples the pins at this edge; release them for the next cycle
                    r_csb <= 1'b1;
                    r_web <= 1'b1;
                    if (r_is_write) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_we    <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_wr_count  <= r_wr_count + CNT_WIDTH'(1);
                        r_state     <= StResp;
                    end else begin
                        r_state <= StCapture;
                    end
                end
                StCapture: begin
                    r_rsp_rdata <= sram_dout0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_we    <= 1'b0;
                    r_rd_count  <= r_rd_count + CNT_WIDTH'(1);
                    r_state     <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_we      = r_rsp_we;
    assign rsp_rdata   = r_rsp_rdata;
    assign sram_csb0   = r_csb;
    assign sram_web0   = r_web;
    assign sram_wmask0 = r_wmask;
    assign sram_addr0  = r_addr;
    assign sram_din0   = r_din;
    assign rd_count    = r_rd_count;
    assign wr_count    = r_wr_count;

endmodule

// File: tb/tb_sram_port0_ctrl.sv
// tb_sram_port0_ctrl
// Directed bench for sram_port0_ctrl with a behavioural model of the SRAM macro: pins are
// sampled on the rising edge, and the write or read-out happens on the following falling edge.
module tb_sram_port0_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_we;
    logic [31:0] rsp_rdata;
    logic        sram_csb0;
    logic        sram_web0;
    logic [3:0]  sram_wmask0;
    logic [7:0]  sram_addr0;
    logic [31:0] sram_din0;
    logic [31:0] sram_dout0;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    sram_port0_ctrl #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(8),
        .NUM_WMASKS(4),
        .CNT_WIDTH (16)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_we     (rsp_we),
        .rsp_rdata  (rsp_rdata),
        .sram_csb0  (sram_csb0),
        .sram_web0  (sram_web0),
        .sram_wmask0(sram_wmask0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_dout0 (sram_dout0),
        .rd_count   (rd_count),
        .wr_count   (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Macro model
    logic [31:0] mem [256];
    logic        m_pend;
    logic        m_we;
    logic [7:0]  m_addr;
    logic [31:0] m_din;
    logic [3:0]  m_mask;

    always @(posedge clk) begin
        m_pend <= ~sram_csb0;
        m_we   <= ~sram_web0;
        m_addr <= sram_addr0;
        m_din  <= sram_din0;
        m_mask <= sram_wmask0;
    end

    always @(negedge clk) begin
        if (m_pend) begin
            if (m_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (m_mask[b]) mem[m_addr][8*b +: 8] <= m_din[8*b +: 8];
                end
            end else begin
                sram_dout0 <= mem[m_addr];
            end
        end
    end

    int unsigned cyc;
    int unsigned csb_low;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!sram_csb0) csb_low <= csb_low + 1;
    end

    int n_pass;
    int n_total;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction with rsp_ready as currently driven; returns data and latency
    task automatic xact(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wmask, output logic [31:0] rdata, output int lat,
                        output logic rwe);
        int guard;
        guard = 0;
        while (!req_ready && guard < 20) begin
            tick();
            guard++;
        end
        if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        tick();
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!rsp_valid) check("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
        rdata = rsp_rdata;
        rwe   = rsp_we;
        if (rsp_ready) tick();
    endtask

    logic [31:0] rd;
    int          lat;
    logic        rwe;
    int unsigned c0;
    int unsigned last_acc;
    int          bad_gap;
    int          bad_data;
    int          guard;

    initial begin
        n_pass    = 0;
        n_total   = 0;
        cyc       = 0;
        csb_low   = 0;
        m_pend    = 1'b0;
        m_we      = 1'b0;
        m_addr    = '0;
        m_din     = '0;
        m_mask    = '0;
        sram_dout0 = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
        rsp_ready = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_csb", 32'(sram_csb0), 32'd1);
        check("rst_web", 32'(sram_web0), 32'd1);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rd_count", 32'(rd_count), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);
        check("rst_addr", 32'(sram_addr0), 32'd0);
        rst_n = 1'b1;
        tick();
        check("ready_after_rst", 32'(req_ready), 32'd1);

        // 1: write then read same address
        xact(1'b1, 8'h12, 32'hDEADBEEF, 4'hF, rd, lat, rwe);
        check("t1_wr_lat", 32'(lat), 32'd1);
        check("t1_wr_rsp_we", 32'(rwe), 32'd1);
        check("t1_wr_rdata", rd, 32'h0);
        xact(1'b0, 8'h12, 32'h0, 4'h0, rd, lat, rwe);
        check("t1_rd_lat", 32'(lat), 32'd2);
        check("t1_rd_rsp_we", 32'(rwe), 32'd0);
        check("t1_rd_data", rd, 32'hDEADBEEF);
        check("t1_wr_count", 32'(wr_count), 32'd1);
        check("t1_rd_count", 32'(rd_count), 32'd1);

        // 2: byte-masked overwrite
        xact(1'b1, 8'h05, 32'h11223344, 4'hF, rd, lat, rwe);
        xact(1'b1, 8'h05, 32'hAABBCCDD, 4'b0101, rd, lat, rwe);
        xact(1'b0, 8'h05, 32'h0, 4'h0, rd, lat, rwe);
        check("t2_masked", rd, 32'h11BB33DD);

        // 3: response backpressure
        rsp_ready = 1'b0;
        c0 = csb_low;
        xact(1'b0, 8'h05, 32'h0, 4'h0, rd, lat, rwe);
        check("t3_rdata", rd, 32'h11BB33DD);
        bad_data = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h11BB33DD || req_ready !== 1'b0) begin
                bad_data++;
            end
        end
        check("t3_held", 32'(bad_data), 32'd0);
        check("t3_csb_once", csb_low - c0, 32'd1);
        rsp_ready = 1'b1;
        tick();
        check("t3_ready_back", 32'(req_ready), 32'd1);
        check("t3_valid_clr", 32'(rsp_valid), 32'd0);

        // 4: fill, then streamed reads with req_valid held high
        for (int a = 0; a < 256; a++) begin
            xact(1'b1, 8'(a), 32'(a) * 32'h01010101, 4'hF, rd, lat, rwe);
        end
        c0 = 32'(rd_count);
        bad_gap  = 0;
        bad_data = 0;
        last_acc = 0;
        req_we    = 1'b0;
        req_valid = 1'b1;
        for (int a = 0; a < 256; a++) begin
            req_addr = 8'(a);
            guard = 0;
            while (!req_ready && guard < 20) begin
                tick();
                guard++;
            end
            tick();
            // Accept, ISSUE, CAPTURE, RESP handshake: one accept per 4 edges
            if (a > 0 && (cyc - last_acc) != 4) bad_gap++;
            last_acc = cyc;
            guard = 0;
            while (!rsp_valid && guard < 20) begin
                tick();
                guard++;
            end
            if (rsp_rdata !== 32'(a) * 32'h01010101) bad_data++;
        end
        req_valid = 1'b0;
        tick();
        check("t4_data_errs", 32'(bad_data), 32'd0);
        check("t4_accept_gap", 32'(bad_gap), 32'd0);
        check("t4_rd_count", 32'(rd_count) - c0, 32'd256);
        check("t4_rd_total", 32'(rd_count), 32'd259);

        // 5: reset during CAPTURE
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'h40;
        tick();
        req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t5_csb", 32'(sram_csb0), 32'd1);
        check("t5_web", 32'(sram_web0), 32'd1);
        check("t5_rd_count", 32'(rd_count), 32'd0);
        check("t5_wr_count", 32'(wr_count), 32'd0);
        rst_n = 1'b1;
        tick();
        xact(1'b0, 8'h33, 32'h0, 4'h0, rd, lat, rwe);
        check("t5_fresh_read", rd, 32'h33333333);

        // 6: zero-mask write is acknowledged but leaves data alone
        xact(1'b1, 8'h20, 32'h0F0F0F0F, 4'hF, rd, lat, rwe);
        c0 = 32'(wr_count);
        xact(1'b1, 8'h20, 32'hFFFFFFFF, 4'h0, rd, lat, rwe);
        check("t6_ack_we", 32'(rwe), 32'd1);
        check("t6_wr_inc", 32'(wr_count) - c0, 32'd1);
        xact(1'b0, 8'h20, 32'h0, 4'h0, rd, lat, rwe);
        check("t6_unchanged", rd, 32'h0F0F0F0F);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
